// File: rtl/ahb_si_arbiter_slave_if.sv
// Bus bundle between one slave port's arbiter and its masters: requests and locks in,
// address/data-phase ownership out.
interface ahb_si_arbiter_slave_if #(
    parameter int unsigned MASTER_NUM = 4
) ();
    localparam int unsigned MW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

    logic [MASTER_NUM-1:0] hreq;
    logic [MASTER_NUM-1:0] hlock;
    logic                  hready;
    logic [MASTER_NUM-1:0] hgrant;
    logic [MASTER_NUM-1:0] hsel_data;
    logic [MW-1:0]         hmaster;
    logic                  hmastlock;

    modport slave (
        input  hreq,
        input  hlock,
        input  hready,
        output hgrant,
        output hsel_data,
        output hmaster,
        output hmastlock
    );

    modport master (
        output hreq,
        output hlock,
        output hready,
        input  hgrant,
        input  hsel_data,
        input  hmaster,
        input  hmastlock
    );
endinterface

// File: rtl/ahb_si_arbiter_slave.sv
// Per-slave-port AHB arbiter: picks an address-phase owner (fixed priority or round-robin),
// honours locked sequences, bounds unlocked tenure, and tracks the data-phase owner.
module ahb_si_arbiter_slave #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned ARB_TYPE   = 1,
    parameter int unsigned MAX_HOLD   = 16
) (
    input logic                   HCLK,
    input logic                   HRESET,
    ahb_si_arbiter_slave_if.slave bus
);
    localparam int unsigned MW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StOwned, StLocked} state_e;

    state_e                state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [MASTER_NUM-1:0] data_q, data_d;
    logic [MW-1:0]         owner_q, owner_d;
    logic                  lock_q, lock_d;
    logic [CW-1:0]         hold_q, hold_d;
    logic [MW-1:0]         rr_q, rr_d;

    logic [MASTER_NUM-1:0] others;
    logic [MASTER_NUM-1:0] cand;
    logic [MW-1:0]         win;
    logic                  take_new;
    logic                  go_idle;
    logic                  keep;

    // Round-robin scans from last+1 upward; descending loop lets the nearest hit win.
    function automatic logic [MW-1:0] pick_winner(input logic [MASTER_NUM-1:0] req,
                                                  input logic [MW-1:0] last);
        logic [MW-1:0] w;
        int unsigned   idx;
        w = '0;
        if (ARB_TYPE == 0) begin
            for (int i = int'(MASTER_NUM) - 1; i >= 0; i--) begin
                if (req[i]) w = MW'(i);
            end
        end else begin
            for (int unsigned s = MASTER_NUM; s >= 1; s--) begin
                idx = (32'(last) + s) % MASTER_NUM;
                if (req[idx]) w = MW'(idx);
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        data_d   = data_q;
        owner_d  = owner_q;
        lock_d   = lock_q;
        hold_d   = hold_q;
        rr_d     = rr_q;
        take_new = 1'b0;
        go_idle  = 1'b0;
        keep     = 1'b0;
        cand     = '0;
        others   = bus.hreq & ~grant_q;

        if (bus.hready) begin
            data_d = grant_q;
            unique case (state_q)
                StIdle: begin
                    if (|bus.hreq) begin
                        take_new = 1'b1;
                        cand     = bus.hreq;
                    end
                end
                StOwned, StLocked: begin
                    if (state_q == StLocked && bus.hlock[owner_q]) begin
                        // Locked sequence continues regardless of the owner's request.
                    end else if (!bus.hreq[owner_q]) begin
                        if (|others) begin
                            take_new = 1'b1;
                            cand     = others;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else if (hold_q == HOLD_LAST && |others) begin
                        take_new = 1'b1;
                        cand     = others;
                    end else begin
                        keep = 1'b1;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        win = pick_winner(cand, rr_q);

        if (take_new) begin
            grant_d = MASTER_NUM'(1) << win;
            owner_d = win;
            lock_d  = bus.hlock[win];
            state_d = bus.hlock[win] ? StLocked : StOwned;
            hold_d  = '0;
            rr_d    = win;
        end else if (go_idle) begin
            grant_d = '0;
            owner_d = '0;
            lock_d  = 1'b0;
            state_d = StIdle;
            hold_d  = '0;
        end else if (keep) begin
            // A kept owner that raises its lock starts a locked sequence in place.
            if (bus.hlock[owner_q]) begin
                lock_d  = 1'b1;
                state_d = StLocked;
                hold_d  = '0;
            end else begin
                lock_d  = 1'b0;
                state_d = StOwned;
                if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            grant_q <= '0;
            data_q  <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            hold_q  <= '0;
            rr_q    <= MW'(MASTER_NUM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hsel_data = data_q;
    assign bus.hmaster   = owner_q;
    assign bus.hmastlock = lock_q;
endmodule
